serial_add_sub: RTL and testbench
=================================

# serial_add_sub

Digit-serial, parametrised wide adder/subtractor for the BLS12-381 field-arithmetic datapath. It accepts two WIDTH-bit operands and adds or subtracts them DIGIT bits per cycle, rippling one carry/borrow bit between digits, the same way the 1-bit full adder chains carries. It returns the WIDTH-bit result plus the final carry or borrow over a valid/ready handshake. It is the building block for the modular add/sub and Montgomery reduction stages, where a full 384-bit carry chain cannot close timing.

## Interface
- WIDTH, 384: operand and result width in bits.
- DIGIT, 64: bits processed per cycle. Must divide WIDTH exactly and be ≥1; any other value is an elaboration error. NUM_DIGITS = WIDTH/DIGIT.
- clk  input  1  the single clock. All state updates on the rising edge.
- rst  input  1  reset, synchronous and active-high.
- in_valid  input  1  operands and mode are valid.
- in_ready  output  1  block can accept a new operation.
- a  input  WIDTH  operand A, unsigned.
- b  input  WIDTH  operand B, unsigned.
- sub  input  1  0 computes a+b; 1 computes a−b.
- out_valid  output  1  result is valid.
- out_ready  input  1  consumer accepts the result.
- result  output  WIDTH  (a±b) mod 2^WIDTH.
- cout  output  1  add: carry out of the MSB. Sub: borrow, which is 1 iff a<b.

## Operation
- States are IDLE, RUN and DONE. in_ready = (state==IDLE). out_valid = (state==DONE).
- **IDLE:**
  - When in_valid && in_ready, register a, b and sub.
  - Initialise the carry register to sub (two's-complement +1).
  - Clear the digit counter to 0 and go to RUN.
- **RUN:** each cycle processes digit i = counter, where digit i is bits [i·DIGIT +: DIGIT].
  - Compute {c, s} = a_i + (b_i XOR {DIGIT{sub_r}}) + carry.
  - Write s into the result digit i and store c in the carry register.
  - Increment the counter.
  - When counter == NUM_DIGITS−1, the cycle processes the last digit, then go to DONE.
- **DONE:**
  - Hold result stable.
  - cout = carry_r XOR sub_r, i.e. the raw carry for add and the inverted carry (borrow) for sub.
  - When out_ready is high, go to IDLE.
- Inputs a, b and sub are ignored outside the accepting cycle. Changing them during RUN has no effect.
- in_valid while busy is not accepted. The upstream holds in_valid until in_ready.
- result and cout change only during RUN and are stable for the whole DONE period.
- When DIGIT == WIDTH, RUN lasts exactly one cycle.

## Timing
- **Reset values:**
  - State = IDLE, so in_ready = 1 and out_valid = 0.
  - result = 0, cout = 0, counter = 0, carry register = 0.
- Reset has priority over every other event. rst asserted in RUN or DONE aborts the operation and discards the result. The cycle after rst deasserts, the block is IDLE with in_ready = 1.
- **Latency:**
  - Call the accept edge E0. out_valid rises after edge E0+NUM_DIGITS, i.e. 6 cycles for the defaults.
  - If out_ready is already high, out_valid is high for exactly 1 cycle.
- **Throughput:** at most one operation per NUM_DIGITS+2 cycles (accept, NUM_DIGITS RUN cycles, DONE). in_ready rises the cycle after the DONE handshake. There is no overlap of operations.
- **Back-pressure:** out_ready low in DONE holds out_valid, result and cout indefinitely.
- Critical path is one DIGIT-bit adder plus a mux. The carry between digits is registered, so there is no combinational path from inputs to outputs except through state.

## Test plan
- **Add with carry ripple across all digits:** a = 2^384−1, b = 1, sub = 0.
  - result = 0, cout = 1.
  - out_valid rises exactly 6 edges after accept.
- **Subtract with borrow:** a = 0, b = 1, sub = 1.
  - result = 2^384−1, cout = 1.
- **Subtract without borrow, BLS12-381 modulus:** a = p, b = p−1, where p is the BLS12-381 modulus.
  - result = 1, cout = 0.
- **Back-pressure and input isolation:**
  - Hold out_ready = 0 for 10 cycles in DONE.
  - out_valid stays 1, result and cout stay constant, and in_ready stays 0.
  - Toggling a, b, sub and in_valid during RUN and DONE has no effect.
- **Reset mid-operation:** assert rst on the 3rd RUN cycle.
  - Next cycle: in_ready = 1, out_valid = 0, result = 0.
  - A fresh operation 5+7 then completes with result = 12 and cout = 0.
- **Parameter sweep:** DIGIT ∈ {1, 32, 384} with WIDTH = 384, plus WIDTH = 64 with DIGIT = 16.
  - 1000 random add and sub operations each with random out_ready stalls.
  - result and cout match a reference model in every case.
  - Latency equals WIDTH/DIGIT in every case.

Source files
------------

// File: rtl/serial_add_sub.sv
// Digit-serial WIDTH-bit adder/subtractor, DIGIT bits per cycle with a registered carry between digits.
// Latency: result valid WIDTH/DIGIT cycles after the accept edge; throughput one op per WIDTH/DIGIT+2 cycles.
// Backpressure: out_valid, result and cout hold in DONE until out_ready; in_ready stays low while busy.
//
// Ports:
//   clk, rst              single clock, synchronous active-high reset
//   in_valid / in_ready   operand handshake (a, b, sub sampled only on the accept edge)
//   a, b                  WIDTH-bit unsigned operands
//   sub                   0: a+b, 1: a-b
//   out_valid / out_ready result handshake
//   result                (a +/- b) mod 2^WIDTH
//   cout                  add: carry out of the MSB; sub: borrow (1 iff a < b)
module serial_add_sub #(
    parameter int WIDTH = 384,
    parameter int DIGIT = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             cout
);

    // Guarded so an illegal DIGIT reports the error below instead of dividing by zero.
    localparam int NUM_DIGITS = (DIGIT < 1) ? 1 : WIDTH / DIGIT;
    localparam int CW         = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int IW         = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    generate
        if (DIGIT < 1) begin : g_bad_digit
            $error("serial_add_sub: DIGIT must be >= 1");
        end else if ((WIDTH % DIGIT) != 0) begin : g_bad_div
            $error("serial_add_sub: DIGIT must divide WIDTH exactly");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state_q;
    logic [WIDTH-1:0]  a_q;
    logic [WIDTH-1:0]  b_q;
    logic              sub_q;
    logic              carry_q;
    logic [CW-1:0]     cnt_q;
    logic [WIDTH-1:0]  result_q;
    logic              cout_q;
    logic              in_ready_q;
    logic              out_valid_q;

    logic [IW-1:0]     base;
    logic [DIGIT-1:0]  a_dig;
    logic [DIGIT-1:0]  b_dig;
    logic [DIGIT:0]    dsum_d;
    logic              last;

    // Bit offset of the digit being processed. Truncation to IW bits is safe:
    // the largest base is WIDTH-DIGIT, and when DIGIT == WIDTH the counter is always 0.
    assign base = IW'(cnt_q) * IW'(DIGIT);
    assign last = (cnt_q == CW'(NUM_DIGITS - 1));

    always_comb begin
        a_dig  = a_q[base +: DIGIT];
        // Subtraction as a + ~b + 1; the +1 enters through the carry seeded with sub at accept.
        b_dig  = b_q[base +: DIGIT] ^ {DIGIT{sub_q}};
        dsum_d = {1'b0, a_dig} + {1'b0, b_dig} + {{DIGIT{1'b0}}, carry_q};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            a_q         <= '0;
            b_q         <= '0;
            sub_q       <= 1'b0;
            carry_q     <= 1'b0;
            cnt_q       <= '0;
            result_q    <= '0;
            cout_q      <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        a_q        <= a;
                        b_q        <= b;
                        sub_q      <= sub;
                        carry_q    <= sub;
                        cnt_q      <= '0;
                        state_q    <= RUN;
                        in_ready_q <= 1'b0;
                    end
                end
                RUN: begin
                    result_q[base +: DIGIT] <= dsum_d[DIGIT-1:0];
                    carry_q                 <= dsum_d[DIGIT];
                    if (last) begin
                        // Final carry is the add carry-out; inverted it is the subtract borrow.
                        cout_q      <= dsum_d[DIGIT] ^ sub_q;
                        cnt_q       <= '0;
                        state_q     <= DONE;
                        out_valid_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_q     <= IDLE;
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign cout      = cout_q;

endmodule

// File: tb/tb_serial_add_sub.sv
// Self-checking bench for serial_add_sub: directed corner cases on the default 384/64 instance,
// plus randomized add/sub sweeps on 384/1, 384/32, 384/384 and 64/16 against an arithmetic model.
// All outputs are sampled 1 time unit after the rising edge; inputs are driven at the same point.
module tb_serial_add_sub;

    localparam int CKW = 384;
    localparam logic [383:0] P_BLS =
        384'h1a0111ea397fe69a4b1ba7b6434bacd764774b84f38512bf6730d2a0f6b0f6241eabfffeb153ffffb9feffffffffaaab;

    logic clk;
    logic rst;
    logic sw_rst;
    logic sw_go;
    logic [3:0] sw_done;

    int n_checks = 0;
    int n_errors = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [CKW-1:0] obs, input logic [CKW-1:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [383:0] rnd384();
        logic [383:0] v;
        for (int k = 0; k < 12; k++) v[k*32 +: 32] = $urandom;
        return v;
    endfunction

    // ---------------- default-parameter instance ----------------
    logic         m_iv, m_ir, m_sub, m_ov, m_or, m_cout;
    logic [383:0] m_a, m_b, m_res;

    serial_add_sub #(.WIDTH(384), .DIGIT(64)) u_main (
        .clk(clk), .rst(rst),
        .in_valid(m_iv), .in_ready(m_ir),
        .a(m_a), .b(m_b), .sub(m_sub),
        .out_valid(m_ov), .out_ready(m_or),
        .result(m_res), .cout(m_cout)
    );

    task automatic op_main(input string tag, input logic [383:0] ta, input logic [383:0] tbv,
                           input logic ts, input int stall);
        logic [384:0] t;
        logic [383:0] er;
        logic         ec;
        int           lat;
        if (ts) begin
            t  = {1'b0, ta} - {1'b0, tbv};
            ec = (ta < tbv);
        end else begin
            t  = {1'b0, ta} + {1'b0, tbv};
            ec = t[384];
        end
        er = t[383:0];

        chk({tag, "_in_ready"}, CKW'(m_ir), CKW'(1));
        m_a = ta; m_b = tbv; m_sub = ts; m_iv = 1'b1; m_or = (stall == 0);
        @(posedge clk); #1;
        lat = 0;
        // Garbage on every input during RUN must not disturb the operation.
        while (!m_ov && lat < 20) begin
            m_a = rnd384(); m_b = rnd384(); m_sub = 1'($urandom); m_iv = 1'($urandom);
            @(posedge clk); #1;
            lat++;
        end
        chk({tag, "_latency"}, CKW'(lat), CKW'(6));
        chk({tag, "_result"}, m_res, er);
        chk({tag, "_cout"}, CKW'(m_cout), CKW'(ec));
        for (int k = 0; k < stall; k++) begin
            m_a = rnd384(); m_b = rnd384(); m_sub = 1'($urandom); m_iv = 1'($urandom);
            @(posedge clk); #1;
            chk({tag, "_hold_valid"}, CKW'(m_ov), CKW'(1));
            chk({tag, "_hold_result"}, m_res, er);
            chk({tag, "_hold_cout"}, CKW'(m_cout), CKW'(ec));
            chk({tag, "_hold_in_ready"}, CKW'(m_ir), CKW'(0));
        end
        m_iv = 1'b0; m_or = 1'b1;
        @(posedge clk); #1;
        chk({tag, "_valid_drop"}, CKW'(m_ov), CKW'(0));
        chk({tag, "_ready_back"}, CKW'(m_ir), CKW'(1));
        m_or = 1'b0;
    endtask

    // ---------------- parameter sweep instances ----------------
    for (genvar g = 0; g < 4; g++) begin : sw
        localparam int W    = (g == 3) ? 64 : 384;
        localparam int D    = (g == 0) ? 1 : (g == 1) ? 32 : (g == 2) ? 384 : 16;
        localparam int N    = W / D;
        localparam int NOPS = (D == 1) ? 50 : 1000;

        logic         s_iv, s_ir, s_sub, s_ov, s_or, s_cout, done_l;
        logic [W-1:0] s_a, s_b, s_res;

        serial_add_sub #(.WIDTH(W), .DIGIT(D)) u_dut (
            .clk(clk), .rst(sw_rst),
            .in_valid(s_iv), .in_ready(s_ir),
            .a(s_a), .b(s_b), .sub(s_sub),
            .out_valid(s_ov), .out_ready(s_or),
            .result(s_res), .cout(s_cout)
        );

        assign sw_done[g] = done_l;

        function automatic logic [W-1:0] rndw();
            logic [W-1:0] v;
            for (int k = 0; k < W / 32; k++) v[k*32 +: 32] = $urandom;
            case ($urandom % 8)
                0: v = '0;
                1: v = '1;
                default: ;
            endcase
            return v;
        endfunction

        initial begin
            logic [W-1:0] ea, eb, er;
            logic [W:0]   t;
            logic         es, ec, hs;
            int           lat, guard;
            string        pfx;
            pfx = $sformatf("sw%0d", g);
            s_iv = 1'b0; s_or = 1'b0; s_a = '0; s_b = '0; s_sub = 1'b0; done_l = 1'b0;
            wait (sw_go);
            @(posedge clk); #1;
            for (int n = 0; n < NOPS; n++) begin
                ea = rndw();
                eb = ($urandom % 16 == 0) ? ea : rndw();
                es = 1'($urandom);
                if (es) begin
                    t  = {1'b0, ea} - {1'b0, eb};
                    ec = (ea < eb);
                end else begin
                    t  = {1'b0, ea} + {1'b0, eb};
                    ec = t[W];
                end
                er = t[W-1:0];

                chk({pfx, "_in_ready"}, CKW'(s_ir), CKW'(1));
                s_a = ea; s_b = eb; s_sub = es; s_iv = 1'b1;
                @(posedge clk); #1;
                s_iv = 1'b0;
                lat = 0;
                while (!s_ov && lat < N + 4) begin
                    s_or = 1'($urandom);
                    @(posedge clk); #1;
                    lat++;
                end
                chk({pfx, "_latency"}, CKW'(lat), CKW'(N));
                chk({pfx, "_result"}, CKW'(s_res), CKW'(er));
                chk({pfx, "_cout"}, CKW'(s_cout), CKW'(ec));

                hs = 1'b0;
                guard = 0;
                while (!hs && guard < 64) begin
                    s_or = 1'($urandom);
                    hs = s_or;
                    @(posedge clk); #1;
                    guard++;
                    if (!hs) chk({pfx, "_stall_result"}, CKW'(s_res), CKW'(er));
                end
                chk({pfx, "_handshake"}, CKW'(hs), CKW'(1));
                chk({pfx, "_ready_back"}, CKW'(s_ir), CKW'(1));
            end
            done_l = 1'b1;
        end
    end

    // ---------------- directed sequence ----------------
    initial begin
        rst = 1'b1; sw_rst = 1'b1; sw_go = 1'b0;
        m_iv = 1'b0; m_or = 1'b0; m_a = '0; m_b = '0; m_sub = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_in_ready", CKW'(m_ir), CKW'(1));
        chk("reset_out_valid", CKW'(m_ov), CKW'(0));
        chk("reset_result", m_res, '0);
        chk("reset_cout", CKW'(m_cout), CKW'(0));
        rst = 1'b0; sw_rst = 1'b0; sw_go = 1'b1;
        @(posedge clk); #1;

        op_main("add_ripple", {384{1'b1}}, 384'd1, 1'b0, 0);
        op_main("sub_borrow", 384'd0, 384'd1, 1'b1, 0);
        op_main("sub_modulus", P_BLS, P_BLS - 384'd1, 1'b1, 0);
        op_main("backpressure", rnd384(), rnd384(), 1'b0, 10);

        // Abort an operation on its third RUN cycle; result from the previous op is nonzero.
        chk("abort_pre_ready", CKW'(m_ir), CKW'(1));
        m_a = rnd384(); m_b = rnd384(); m_sub = 1'b0; m_iv = 1'b1;
        @(posedge clk); #1;
        m_iv = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("abort_in_ready", CKW'(m_ir), CKW'(1));
        chk("abort_out_valid", CKW'(m_ov), CKW'(0));
        chk("abort_result", m_res, '0);
        op_main("after_abort", 384'd5, 384'd7, 1'b0, 0);

        for (int n = 0; n < 20; n++)
            op_main("main_rand", rnd384(), rnd384(), 1'($urandom), int'($urandom % 4));

        for (int k = 0; k < 80000 && sw_done != 4'hF; k++) @(posedge clk);
        #1;
        chk("sweep_complete", CKW'(sw_done), CKW'(4'hF));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
